// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges load returns and the ALU/link
// writeback stream onto one registered write port. Loads always win; ALU
// results that lose arbitration wait in an in-order skid FIFO, and the ALU
// stream is stalled through ALU_READY while that FIFO is full.
module wb_port_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REGW  = 5,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNTW  = 16
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         ALU_VALID,
    input  logic [REGW-1:0]              ALU_RD,
    input  logic [XLEN-1:0]              ALU_DATA,
    output logic                         ALU_READY,
    input  logic                         LD_VALID,
    input  logic [REGW-1:0]              LD_RD,
    input  logic [XLEN-1:0]              LD_DATA,
    output logic                         RF_WE,
    output logic [REGW-1:0]              RF_WADDR,
    output logic [XLEN-1:0]              RF_WDATA,
    output logic [$clog2(DEPTH+1)-1:0]   FIFO_COUNT,
    output logic [CNTW-1:0]              STALL_CNT
);

    localparam int unsigned FCW  = $clog2(DEPTH + 1);
    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [FCW-1:0]  DEPTH_C  = FCW'(DEPTH);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);

    // Skid FIFO storage (contents need no reset; occupancy gates their use)
    logic [REGW-1:0] rd_mem_q   [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];

    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]  count_q,  count_d;
    logic [CNTW-1:0] stall_q,  stall_d;

    logic            we_q,    we_d;
    logic [REGW-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic ready;
    logic alu_accept;
    logic alu_keep;
    logic ld_win;
    logic push;
    logic pop;

    assign ready      = RST_N && (count_q < DEPTH_C);
    assign alu_accept = ALU_VALID && ready;
    // Accepted writes to x0 are consumed here and never reach the FIFO or port
    assign alu_keep   = alu_accept && (ALU_RD != '0);
    assign ld_win     = LD_VALID && (LD_RD != '0);

    // Priority arbitration: load, then FIFO head, then ALU bypass, else idle
    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (ld_win) begin
            we_d    = 1'b1;
            waddr_d = LD_RD;
            wdata_d = LD_DATA;
            push    = alu_keep;
        end else if (count_q != '0) begin
            we_d    = 1'b1;
            waddr_d = rd_mem_q[rd_ptr_q];
            wdata_d = data_mem_q[rd_ptr_q];
            pop     = 1'b1;
            push    = alu_keep;
        end else if (alu_keep) begin
            we_d    = 1'b1;
            waddr_d = ALU_RD;
            wdata_d = ALU_DATA;
        end
    end

    // FIFO pointer and occupancy update; pointers wrap modulo DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTRW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + FCW'(1);
            2'b01:   count_d = count_q - FCW'(1);
            default: count_d = count_q;
        endcase
    end

    // Saturating count of cycles where the ALU stream was held off
    always_comb begin
        stall_d = stall_q;
        if (ALU_VALID && !ready && (stall_q != '1)) begin
            stall_d = stall_q + CNTW'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // FIFO storage write at the tail
    always_ff @(posedge CLK) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= ALU_RD;
            data_mem_q[wr_ptr_q] <= ALU_DATA;
        end
    end

    assign ALU_READY  = ready;
    assign RF_WE      = we_q;
    assign RF_WADDR   = waddr_q;
    assign RF_WDATA   = wdata_q;
    assign FIFO_COUNT = count_q;
    assign STALL_CNT  = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed table-driven bench for wb_port_arbiter, plus hand sequences for
// stall-counter saturation and asynchronous reset in the middle of traffic.
module tb_wb_port_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REGW  = 5;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNTW  = 4;

  logic            CLK;
  logic            RST_N;
  logic            ALU_VALID;
  logic [4:0]      ALU_RD;
  logic [31:0]     ALU_DATA;
  logic            ALU_READY;
  logic            LD_VALID;
  logic [4:0]      LD_RD;
  logic [31:0]     LD_DATA;
  logic            RF_WE;
  logic [4:0]      RF_WADDR;
  logic [31:0]     RF_WDATA;
  logic [1:0]      FIFO_COUNT;
  logic [3:0]      STALL_CNT;

  int n_vec;
  int n_miss;

  wb_port_arbiter #(
    .XLEN (XLEN),
    .REGW (REGW),
    .DEPTH(DEPTH),
    .CNTW (CNTW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ALU_VALID (ALU_VALID),
    .ALU_RD    (ALU_RD),
    .ALU_DATA  (ALU_DATA),
    .ALU_READY (ALU_READY),
    .LD_VALID  (LD_VALID),
    .LD_RD     (LD_RD),
    .LD_DATA   (LD_DATA),
    .RF_WE     (RF_WE),
    .RF_WADDR  (RF_WADDR),
    .RF_WDATA  (RF_WDATA),
    .FIFO_COUNT(FIFO_COUNT),
    .STALL_CNT (STALL_CNT)
  );

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        ld_v;
    logic [4:0]  ld_rd;
    logic [31:0] ld_d;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  cnt;
    logic        rdy;
    logic [3:0]  st;
  } vec_t;

  localparam int unsigned NV = 25;
  vec_t vecs [NV];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic we, input logic [4:0] addr, input logic [31:0] data,
    input logic [1:0] cnt, input logic rdy, input logic [3:0] st);
    vec_t v;
    v.alu_v = av;  v.alu_rd = ard; v.alu_d = ad;
    v.ld_v  = lv;  v.ld_rd  = lrd; v.ld_d  = ld;
    v.we    = we;  v.addr   = addr; v.data = data;
    v.cnt   = cnt; v.rdy    = rdy;  v.st   = st;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    ALU_VALID = av;
    ALU_RD    = ard;
    ALU_DATA  = ad;
    LD_VALID  = lv;
    LD_RD     = lrd;
    LD_DATA   = ld;
  endtask

  task automatic check(input string name, input logic we, input logic [4:0] addr,
                       input logic [31:0] data, input logic [1:0] cnt,
                       input logic rdy, input logic [3:0] st);
    n_vec++;
    if (RF_WE !== we) begin
      $display("FAIL %s RF_WE got %0b want %0b", name, RF_WE, we);
      n_miss++;
    end
    if (RF_WADDR !== addr) begin
      $display("FAIL %s RF_WADDR got %0d want %0d", name, RF_WADDR, addr);
      n_miss++;
    end
    if (RF_WDATA !== data) begin
      $display("FAIL %s RF_WDATA got %h want %h", name, RF_WDATA, data);
      n_miss++;
    end
    if (FIFO_COUNT !== cnt) begin
      $display("FAIL %s FIFO_COUNT got %0d want %0d", name, FIFO_COUNT, cnt);
      n_miss++;
    end
    if (ALU_READY !== rdy) begin
      $display("FAIL %s ALU_READY got %0b want %0b", name, ALU_READY, rdy);
      n_miss++;
    end
    if (STALL_CNT !== st) begin
      $display("FAIL %s STALL_CNT got %0d want %0d", name, STALL_CNT, st);
      n_miss++;
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    vecs[0]  = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      2'd0, 1, 4'd0);
    vecs[1]  = mk(1, 5'd5,  32'h1234,   0, 5'd0,  32'h0,      1, 5'd5,  32'h1234,   2'd0, 1, 4'd0);
    vecs[2]  = mk(1, 5'd4,  32'hBBBB,   1, 5'd3,  32'hAAAA,   1, 5'd3,  32'hAAAA,   2'd1, 1, 4'd0);
    vecs[3]  = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd4,  32'hBBBB,   2'd0, 1, 4'd0);
    vecs[4]  = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd4,  32'hBBBB,   2'd0, 1, 4'd0);
    vecs[5]  = mk(1, 5'd0,  32'hDEAD,   1, 5'd0,  32'hBEEF,   0, 5'd4,  32'hBBBB,   2'd0, 1, 4'd0);
    vecs[6]  = mk(1, 5'd7,  32'h7777,   1, 5'd0,  32'hCCCC,   1, 5'd7,  32'h7777,   2'd0, 1, 4'd0);
    vecs[7]  = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd7,  32'h7777,   2'd0, 1, 4'd0);
    vecs[8]  = mk(1, 5'd10, 32'h100A,   1, 5'd20, 32'h2001,   1, 5'd20, 32'h2001,   2'd1, 1, 4'd0);
    vecs[9]  = mk(1, 5'd11, 32'h100B,   1, 5'd21, 32'h2002,   1, 5'd21, 32'h2002,   2'd2, 0, 4'd0);
    vecs[10] = mk(1, 5'd12, 32'h100C,   1, 5'd22, 32'h2003,   1, 5'd22, 32'h2003,   2'd2, 0, 4'd1);
    vecs[11] = mk(1, 5'd12, 32'h100C,   1, 5'd23, 32'h2004,   1, 5'd23, 32'h2004,   2'd2, 0, 4'd2);
    vecs[12] = mk(1, 5'd12, 32'h100C,   0, 5'd0,  32'h0,      1, 5'd10, 32'h100A,   2'd1, 1, 4'd3);
    vecs[13] = mk(1, 5'd12, 32'h100C,   0, 5'd0,  32'h0,      1, 5'd11, 32'h100B,   2'd1, 1, 4'd3);
    vecs[14] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd12, 32'h100C,   2'd0, 1, 4'd3);
    vecs[15] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd12, 32'h100C,   2'd0, 1, 4'd3);
    vecs[16] = mk(1, 5'd1,  32'h3001,   0, 5'd0,  32'h0,      1, 5'd1,  32'h3001,   2'd0, 1, 4'd3);
    vecs[17] = mk(1, 5'd2,  32'h3002,   1, 5'd24, 32'h4001,   1, 5'd24, 32'h4001,   2'd1, 1, 4'd3);
    vecs[18] = mk(1, 5'd3,  32'h3003,   0, 5'd0,  32'h0,      1, 5'd2,  32'h3002,   2'd1, 1, 4'd3);
    vecs[19] = mk(1, 5'd4,  32'h3004,   1, 5'd25, 32'h4002,   1, 5'd25, 32'h4002,   2'd2, 0, 4'd3);
    vecs[20] = mk(1, 5'd5,  32'h3005,   0, 5'd0,  32'h0,      1, 5'd3,  32'h3003,   2'd1, 1, 4'd4);
    vecs[21] = mk(1, 5'd5,  32'h3005,   0, 5'd0,  32'h0,      1, 5'd4,  32'h3004,   2'd1, 1, 4'd4);
    vecs[22] = mk(1, 5'd6,  32'h3006,   0, 5'd0,  32'h0,      1, 5'd5,  32'h3005,   2'd1, 1, 4'd4);
    vecs[23] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd6,  32'h3006,   2'd0, 1, 4'd4);
    vecs[24] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd6,  32'h3006,   2'd0, 1, 4'd4);

    RST_N = 1'b0;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    repeat (2) @(posedge CLK);
    #1 check("reset_state", 0, 5'd0, 32'h0, 2'd0, 0, 4'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int unsigned i = 0; i < NV; i++) begin
      @(negedge CLK);
      drive(vecs[i].alu_v, vecs[i].alu_rd, vecs[i].alu_d,
            vecs[i].ld_v, vecs[i].ld_rd, vecs[i].ld_d);
      @(posedge CLK);
      #1 check($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
               vecs[i].cnt, vecs[i].rdy, vecs[i].st);
    end

    @(negedge CLK);
    drive(1, 5'd8, 32'h5001, 1, 5'd26, 32'h6001);
    @(posedge CLK);
    #1 check("fill1", 1, 5'd26, 32'h6001, 2'd1, 1, 4'd4);
    @(negedge CLK);
    drive(1, 5'd9, 32'h5002, 1, 5'd27, 32'h6002);
    @(posedge CLK);
    #1 check("fill2", 1, 5'd27, 32'h6002, 2'd2, 0, 4'd4);

    for (int unsigned k = 1; k <= 12; k++) begin
      int unsigned e;
      e = 4 + k;
      if (e > 15) e = 15;
      @(negedge CLK);
      drive(1, 5'd13, 32'h5003, 1, 5'd28, 32'h6003);
      @(posedge CLK);
      #1 check($sformatf("stall%0d", k), 1, 5'd28, 32'h6003, 2'd2, 0, 4'(e));
    end

    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 check("async_reset", 0, 5'd0, 32'h0, 2'd0, 0, 4'd0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    @(posedge CLK);
    #1 check("reset_hold", 0, 5'd0, 32'h0, 2'd0, 0, 4'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1 check("reset_release", 0, 5'd0, 32'h0, 2'd0, 1, 4'd0);

    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge CLK);
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(posedge CLK);
      #1 check($sformatf("post_reset%0d", k), 0, 5'd0, 32'h0, 2'd0, 1, 4'd0);
    end

    @(negedge CLK);
    drive(1, 5'd15, 32'h9999, 0, 5'd0, 32'h0);
    @(posedge CLK);
    #1 check("post_reset_bypass", 1, 5'd15, 32'h9999, 2'd0, 1, 4'd0);
    @(negedge CLK);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
